// File: rtl/sap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sap_ctrl_if
//  Description : Control-word bundle between the SAP controller-sequencer and
//                the datapath (fetch side, execute stage, output register).
//  Revision    : 1.0  initial release
// ============================================================================
interface sap_ctrl_if #(
  parameter int T_STATES = 6,
  parameter int OP_W     = 4
);
  logic                step_en;
  logic [OP_W-1:0]     opcode;
  logic [T_STATES-1:0] t_state;
  logic                cp;
  logic                ep;
  logic                lm_n;
  logic                ce_n;
  logic                li_n;
  logic                ei_n;
  logic                la_n;
  logic                lb_n;
  logic                lo_n;
  logic                ea;
  logic                eu;
  logic                su;
  logic                hlt_n;
  logic                halted;

  // Controller side: consumes opcode/step control, produces the control word
  modport master (
    input  step_en, opcode,
    output t_state, cp, ep, lm_n, ce_n, li_n, ei_n,
           la_n, lb_n, lo_n, ea, eu, su, hlt_n, halted
  );

  // Datapath side: supplies opcode/step control, consumes the control word
  modport slave (
    output step_en, opcode,
    input  t_state, cp, ep, lm_n, ce_n, li_n, ei_n,
           la_n, lb_n, lo_n, ea, eu, su, hlt_n, halted
  );
endinterface
`default_nettype wire

// File: rtl/sap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sap_controller
//  Description : Six-state one-hot ring counter with opcode decode producing
//                the SAP control word each T-state. State advances on the
//                falling clock edge so the word is stable a half-cycle before
//                the rising edge where the datapath registers load.
//  Revision    : 1.0  initial release
// ============================================================================
module sap_controller #(
  parameter int T_STATES = 6,
  parameter int OP_W     = 4
) (
  input  logic      clk,
  input  logic      clr_n,
  sap_ctrl_if.master bus
);

  localparam logic [OP_W-1:0] c_OP_LDA = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] c_OP_ADD = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] c_OP_SUB = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] c_OP_OUT = OP_W'(4'b1110);
  localparam logic [OP_W-1:0] c_OP_HLT = OP_W'(4'b1111);

  // Ring encoding is the one-hot t_state value itself (bit0 = T1)
  typedef enum logic [5:0] {
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_halt;
  logic            w_halt_nxt;
  logic [OP_W-1:0] r_op;
  logic [OP_W-1:0] w_op_nxt;

  logic w_cp, w_ep, w_lm_n, w_ce_n, w_li_n, w_ei_n;
  logic w_la_n, w_lb_n, w_lo_n, w_ea, w_eu, w_su, w_hlt_n;

  // State register: ring, halt flag and latched opcode, falling-edge clocked
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_T1;
      r_halt  <= 1'b0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_halt  <= w_halt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state sequencing and control-word decode from the registered state
  always_comb begin
    w_state_nxt = r_state;
    w_halt_nxt  = r_halt;
    w_op_nxt    = r_op;

    w_cp    = 1'b0;
    w_ep    = 1'b0;
    w_lm_n  = 1'b1;
    w_ce_n  = 1'b1;
    w_li_n  = 1'b1;
    w_ei_n  = 1'b1;
    w_la_n  = 1'b1;
    w_lb_n  = 1'b1;
    w_lo_n  = 1'b1;
    w_ea    = 1'b0;
    w_eu    = 1'b0;
    w_su    = 1'b0;
    w_hlt_n = 1'b1;

    // HALT is sticky: ring frozen, step_en and opcode ignored until clr_n
    if (!r_halt && bus.step_en) begin
      case (r_state)
        ST_T1: w_state_nxt = ST_T2;
        ST_T2: w_state_nxt = ST_T3;
        ST_T3: begin
          w_state_nxt = ST_T4;
          w_op_nxt    = bus.opcode;
          w_halt_nxt  = (bus.opcode == c_OP_HLT);
        end
        ST_T4:   w_state_nxt = ST_T5;
        ST_T5:   w_state_nxt = ST_T6;
        ST_T6:   w_state_nxt = ST_T1;
        default: w_state_nxt = ST_T1;
      endcase
    end

    if (r_halt) begin
      w_hlt_n = 1'b0;
    end else begin
      case (r_state)
        ST_T1: begin
          w_ep   = 1'b1;
          w_lm_n = 1'b0;
        end
        ST_T2: w_cp = 1'b1;
        ST_T3: begin
          w_ce_n = 1'b0;
          w_li_n = 1'b0;
        end
        ST_T4: begin
          if (r_op == c_OP_LDA || r_op == c_OP_ADD || r_op == c_OP_SUB) begin
            w_ei_n = 1'b0;
            w_lm_n = 1'b0;
          end else if (r_op == c_OP_OUT) begin
            w_ea   = 1'b1;
            w_lo_n = 1'b0;
          end
        end
        ST_T5: begin
          if (r_op == c_OP_LDA) begin
            w_ce_n = 1'b0;
            w_la_n = 1'b0;
          end else if (r_op == c_OP_ADD || r_op == c_OP_SUB) begin
            w_ce_n = 1'b0;
            w_lb_n = 1'b0;
            w_su   = (r_op == c_OP_SUB);
          end
        end
        ST_T6: begin
          if (r_op == c_OP_ADD || r_op == c_OP_SUB) begin
            w_eu   = 1'b1;
            w_la_n = 1'b0;
            w_su   = (r_op == c_OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.t_state = r_state;
  assign bus.cp      = w_cp;
  assign bus.ep      = w_ep;
  assign bus.lm_n    = w_lm_n;
  assign bus.ce_n    = w_ce_n;
  assign bus.li_n    = w_li_n;
  assign bus.ei_n    = w_ei_n;
  assign bus.la_n    = w_la_n;
  assign bus.lb_n    = w_lb_n;
  assign bus.lo_n    = w_lo_n;
  assign bus.ea      = w_ea;
  assign bus.eu      = w_eu;
  assign bus.su      = w_su;
  assign bus.hlt_n   = w_hlt_n;
  assign bus.halted  = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_sap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sap_controller
//  Description : Self-checking bench for sap_controller. A behavioural model
//                of the ring pushes the expected control word when each edge
//                is driven; the word is popped and compared after the edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sap_controller;

  logic clk;
  logic clr_n;

  sap_ctrl_if #(.T_STATES(6), .OP_W(4)) bus ();

  sap_controller #(.T_STATES(6), .OP_W(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {t_state, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, ea, eu, su, hlt_n, halted}
  logic [19:0] obs;
  assign obs = {bus.t_state, bus.cp, bus.ep, bus.lm_n, bus.ce_n, bus.li_n, bus.ei_n,
                bus.la_n, bus.lb_n, bus.lo_n, bus.ea, bus.eu, bus.su, bus.hlt_n, bus.halted};

  int          checks;
  int          errors;
  logic [19:0] sb_q[$];
  logic [19:0] exp_w;

  // Reference model state
  int       mt;
  logic [3:0] mop;
  bit       mh;

  function automatic logic [19:0] model_word(int t, logic [3:0] op, bit h);
    logic [5:0] ts;
    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, ea, eu, su, hlt_n;
    cp = 0; ep = 0; lm_n = 1; ce_n = 1; li_n = 1; ei_n = 1;
    la_n = 1; lb_n = 1; lo_n = 1; ea = 0; eu = 0; su = 0; hlt_n = 1;
    ts = 6'b000001 << t;
    if (h) begin
      hlt_n = 0;
    end else begin
      case (t)
        0: begin ep = 1; lm_n = 0; end
        1: cp = 1;
        2: begin ce_n = 0; li_n = 0; end
        3: begin
          if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin ei_n = 0; lm_n = 0; end
          else if (op == 4'hE) begin ea = 1; lo_n = 0; end
        end
        4: begin
          if (op == 4'h0) begin ce_n = 0; la_n = 0; end
          else if (op == 4'h1) begin ce_n = 0; lb_n = 0; end
          else if (op == 4'h2) begin ce_n = 0; lb_n = 0; su = 1; end
        end
        5: begin
          if (op == 4'h1) begin eu = 1; la_n = 0; end
          else if (op == 4'h2) begin eu = 1; la_n = 0; su = 1; end
        end
        default: ;
      endcase
    end
    return {ts, cp, ep, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, ea, eu, su, hlt_n, h};
  endfunction

  task automatic model_reset();
    mt = 0; mop = 4'h0; mh = 1'b0;
  endtask

  task automatic model_step();
    if (!mh && bus.step_en) begin
      if (mt == 2) begin
        mop = bus.opcode;
        mh  = (bus.opcode == 4'hF);
        mt  = 3;
      end else begin
        mt = (mt == 5) ? 0 : mt + 1;
      end
    end
  endtask

  // Stimulus side: advance model, push expectation, then let the DUT take the edge
  task automatic drive_edge();
    model_step();
    sb_q.push_back(model_word(mt, mop, mh));
    @(negedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    clr_n = 1'b0;
    model_reset();
    #1;
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    clr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL reset_pre[%0d]: got %b expected %b", i, obs, exp_w);
      end
    end
    @(posedge clk); #2;
    clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 20'b000001_0_1_0_1_1_1_1_1_1_0_0_0_1_0) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs, 20'b000001_0_1_0_1_1_1_1_1_1_0_0_0_1_0);
    end
    clr_n = 1'b1;
    drive_edge();
    exp_w = sb_q.pop_front();
    checks++;
    if (obs !== exp_w || bus.t_state !== 6'b000010 || bus.cp !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, exp_w);
    end
  endtask

  task automatic test_lda_add();
    pulse_reset();
    bus.opcode = 4'h0;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) bus.opcode = 4'h1;
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL lda_add[%0d]: got %b expected %b", i, obs, exp_w);
      end
      if (i == 10) begin
        checks++;
        if ({bus.eu, bus.la_n, bus.su, bus.lb_n} !== 4'b1001) begin
          errors++;
          $display("FAIL add_t6: got eu/la_n/su/lb_n %b expected 1001", {bus.eu, bus.la_n, bus.su, bus.lb_n});
        end
      end
    end
  endtask

  task automatic test_sub();
    pulse_reset();
    bus.opcode = 4'h2;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.opcode = 4'hF;   // change during T5; op already latched
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL sub[%0d]: got %b expected %b", i, obs, exp_w);
      end
      if (i == 4) begin
        checks++;
        if ({bus.t_state, bus.su, bus.eu, bus.hlt_n} !== 9'b100000_1_1_1) begin
          errors++;
          $display("FAIL sub_t6: got %b expected %b", {bus.t_state, bus.su, bus.eu, bus.hlt_n}, 9'b100000_1_1_1);
        end
      end
    end
  endtask

  task automatic test_out_hlt();
    pulse_reset();
    bus.opcode = 4'hE;
    for (int i = 0; i < 19; i++) begin
      if (i == 6) bus.opcode = 4'hF;
      if (i >= 9) begin
        bus.step_en = 1'($urandom_range(0, 1));
        bus.opcode  = 4'($urandom_range(0, 15));
      end
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL out_hlt[%0d]: got %b expected %b", i, obs, exp_w);
      end
    end
    checks++;
    if ({bus.t_state, bus.hlt_n, bus.halted} !== 8'b001000_0_1) begin
      errors++;
      $display("FAIL hlt_hold: got %b expected %b", {bus.t_state, bus.hlt_n, bus.halted}, 8'b001000_0_1);
    end
    bus.step_en = 1'b1;
    clr_n = 1'b0;
    model_reset();
    #1;
    exp_w = model_word(0, 4'h0, 1'b0);
    checks++;
    if (obs !== exp_w) begin
      errors++;
      $display("FAIL hlt_clear: got %b expected %b", obs, exp_w);
    end
    clr_n = 1'b1;
  endtask

  task automatic test_step_abort();
    pulse_reset();
    bus.opcode = 4'h1;
    for (int i = 0; i < 8; i++) begin
      bus.step_en = (i < 5);
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL step_hold[%0d]: got %b expected %b", i, obs, exp_w);
      end
    end
    checks++;
    if ({bus.t_state, bus.eu, bus.la_n} !== 8'b100000_1_0) begin
      errors++;
      $display("FAIL step_t6: got %b expected %b", {bus.t_state, bus.eu, bus.la_n}, 8'b100000_1_0);
    end
    clr_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.t_state, bus.eu, bus.la_n} !== 8'b000001_0_1) begin
      errors++;
      $display("FAIL abort: got %b expected %b", {bus.t_state, bus.eu, bus.la_n}, 8'b000001_0_1);
    end
    clr_n = 1'b1;
    bus.step_en = 1'b1;
  endtask

  task automatic test_step_at_capture();
    pulse_reset();
    bus.opcode = 4'h1;
    for (int i = 0; i < 7; i++) begin
      bus.step_en = (i != 2);
      if (i == 2) bus.opcode = 4'hF;   // held edge must not capture HLT
      if (i == 3) bus.opcode = 4'h2;
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL step_capture[%0d]: got %b expected %b", i, obs, exp_w);
      end
    end
    bus.step_en = 1'b1;
  endtask

  task automatic test_nop();
    pulse_reset();
    bus.opcode = 4'h7;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) bus.opcode = 4'h0;
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL nop[%0d]: got %b expected %b", i, obs, exp_w);
      end
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i < 60; i++) begin
      bus.opcode  = 4'($urandom_range(0, 14));
      bus.step_en = ($urandom_range(0, 3) != 0);
      drive_edge();
      exp_w = sb_q.pop_front();
      checks++;
      if (obs !== exp_w) begin
        errors++;
        $display("FAIL b2b[%0d]: got %b expected %b", i, obs, exp_w);
      end
    end
    bus.step_en = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    clr_n       = 1'b0;
    bus.step_en = 1'b1;
    bus.opcode  = 4'h0;
    model_reset();
    test_reset();
    test_lda_add();
    test_sub();
    test_out_hlt();
    test_step_abort();
    test_step_at_capture();
    test_nop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap_controller.md
# sap_controller

Controller-sequencer for the SAP datapath: a six-state ring counter plus opcode decode that produces the complete control word each T-state. It sits directly upstream of the execute stage (B register, adder/subtractor, accumulator) and the output register. It drives their load/enable strobes (`la_n`, `ea`, `lb_n`, `eu`, `su`, `lo_n`) and the fetch-side strobes. The opcode comes from the upper nibble of the instruction register.

## Interface
Parameters:
- `T_STATES`, 6: ring length (T1..T6); fixed at 6 for this instruction set.
- `OP_W`, 4: opcode width.

Ports:
- `clk`  in  1  system clock; the ring advances on the falling edge.
- `clr_n`  in  1  reset, asynchronous, active-low.
- `step_en`  in  1  1 = ring advances; 0 = hold the current T-state (single-step/debug).
- `opcode`  in  `OP_W`  instruction register upper nibble.
- `t_state`  out  `T_STATES`  one-hot ring state; bit0 = T1.
- `cp`, `ep`  out  1  PC increment and PC enable, active-high.
- `lm_n`, `ce_n`, `li_n`, `ei_n`  out  1  MAR load, RAM enable, IR load, IR enable; active-low.
- `la_n`, `lb_n`, `lo_n`  out  1  accumulator, B register and output register loads; active-low.
- `ea`, `eu`, `su`  out  1  accumulator enable, adder enable, subtract select; active-high.
- `hlt_n`  out  1  halt, active-low.
- `halted`  out  1  status; 1 while in HALT.

## Operation
- State: one-hot ring T1..T6, a HALT flag, and the latched opcode `op_q`.
- Default (inactive) word: `cp`=0, `ep`=0, `lm_n`=1, `ce_n`=1, `li_n`=1, `ei_n`=1, `la_n`=1, `lb_n`=1, `lo_n`=1, `ea`=0, `eu`=0, `su`=0, `hlt_n`=1.
- Each state asserts only the strobes listed; all others stay at default.
- Fetch states, all opcodes:
  - T1: `ep`=1, `lm_n`=0.
  - T2: `cp`=1.
  - T3: `ce_n`=0, `li_n`=0.
- `op_q` captures `opcode` on the falling edge that moves T3 to T4. T4..T6 decode uses only `op_q`.
- LDA (0000):
  - T4: `ei_n`=0, `lm_n`=0.
  - T5: `ce_n`=0, `la_n`=0.
  - T6: idle.
- ADD (0001):
  - T4: `ei_n`=0, `lm_n`=0.
  - T5: `ce_n`=0, `lb_n`=0.
  - T6: `eu`=1, `la_n`=0.
- SUB (0010): same as ADD, plus `su`=1 in T5 and T6.
- OUT (1110):
  - T4: `ea`=1, `lo_n`=0.
  - T5, T6: idle.
- HLT (1111): on the edge into T4, enter HALT.
  - HALT holds `hlt_n`=0 and `halted`=1; all other strobes at default.
  - The ring freezes at T4.
  - Only `clr_n` exits HALT.
- Any other opcode is a NOP: T4..T6 idle.
- The transition out of T6 returns the ring to T1.
- `step_en`=0 holds the ring and `op_q`. Outputs stay at the current state's word, so strobes stay asserted while held.
- Invariants:
  - No state asserts two bus drivers at once: at most one of `ep`, `ce_n`=0, `ei_n`=0, `ea`, `eu`.
  - `eu`=1 never coincides with `lb_n`=0.

## Timing
- Ring, HALT flag and `op_q` update on `negedge clk`.
- Control outputs decode combinationally from the registered state, so they are stable a half-cycle before the `posedge clk` at which downstream registers load.
- Latency:
  - T1 word appears immediately on reset release.
  - Each further T-state follows one falling edge later, with `step_en`=1.
  - A full instruction takes 6 clocks.
- Reset (`clr_n`=0, asynchronous, effective without a clock edge):
  - `t_state`=000001, `op_q`=0, `halted`=0.
  - Outputs are the T1 word: `ep`=1, `lm_n`=0, all else default, `hlt_n`=1.
- Release: the first falling edge with `clr_n`=1 and `step_en`=1 moves to T2.
- Reset mid-instruction (any T-state or HALT) aborts immediately to T1. No partial strobe remains after `clr_n` falls.
- `step_en` deasserted at the same edge as the T3→T4 transition: the ring holds and `op_q` is not captured.
- HALT ignores `step_en` and `opcode`.

## Test plan
- Reset/idle: assert `clr_n`=0 mid-clock-high → `t_state`=000001, `ep`=1, `lm_n`=0, `hlt_n`=1, `halted`=0 with no clock edge. Release, then 1 falling edge → `t_state`=000010, `cp`=1.
- LDA then ADD, `opcode`=0000 then 0001 → 12 falling edges. LDA T5: `la_n`=0, `ce_n`=0. ADD T5: `lb_n`=0. ADD T6: `eu`=1, `la_n`=0, `su`=0. Ring returns to T1 after each T6.
- SUB, `opcode`=0010 → `su`=1 in T5 and T6 only; `eu`=1 only in T6. Change `opcode` to 1111 during T5 → T6 word unchanged (latched `op_q`).
- OUT then HLT → OUT T4: `ea`=1, `lo_n`=0. HLT: entering T4 gives `hlt_n`=0, `halted`=1. 10 further clocks → `t_state` stays 001000. `clr_n` pulse → T1 word.
- Step/abort: `step_en`=0 in ADD T6 for 3 clocks → `eu`=1 and `la_n`=0 held, `t_state`=100000. Then `clr_n`=0 → `eu`=0, `la_n`=1 immediately.
- Unknown opcode 0111 → T4..T6 all strobes at default; next instruction fetches normally.
